accumulator_processor: RTL and testbench
========================================

// Module: accumulator_processor
// PURPOSE
//  Bus-master adder stage that drives the accumulator memory's op/signal/read/write handshake.
//  Each round fetches two operands (A, B), adds them and sends the sum back, so every round
//  reduces the memory population by one.
//  N instances share one memory through an external req/gnt arbiter to form the parallel accumulator.
//  Stops itself when the memory has nothing more to give.
// PARAMETERS
//  DATA_W   32  operand/sum width; must equal memory word width
//  CNT_W    16  width of completed-addition counter
//  GAP      1   idle cycles between end of one transaction and next req (>=1)
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       asynchronous, active-low reset
//  gnt       in   1       arbiter grant; bus owned while gnt=1
//  signal    in   1       memory completion pulse, high exactly one cycle
//  read      in   DATA_W  memory read data, valid when signal=1
//  req       out  1       bus request to arbiter
//  op        out  2       00 NOP, 01 FETCH, 10 SEND; NOP whenever gnt=0
//  write     out  DATA_W  sum to memory, valid while op=SEND
//  busy      out  1       1 in any state other than IDLE/HALT
//  halted    out  1       1 in HALT
//  add_count out  CNT_W   number of sums sent, saturates at all-ones
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; op=NOP, write=0, req=0, busy=0, halted=0, add_count=0,
//   A=B=0. Asserting reset mid-transaction aborts it immediately; the memory is not notified.
//  All outputs are registered. op is a registered value ANDed with gnt.
//  States: IDLE, REQ_A, FET_A, REQ_B, FET_B, ADD, REQ_S, SEND, GAPW, HALT.
//  IDLE -> REQ_A on the first clock after reset release.
//  REQ_x: req=1, op=NOP. The first edge with gnt=1 -> FET_x/SEND.
//  FET_x: op=FETCH held until the cycle signal=1.
//   On that edge: capture read into A or B, op<=NOP, req<=0.
//   The memory ignores op while its signal is high, so op must be NOP by the following edge.
//  After FET_A: A==0 -> HALT (memory exhausted), else GAPW then REQ_B.
//  After FET_B: B==0 -> ADD with sum=A (last live value, returned unchanged), else ADD.
//  ADD: one cycle; write<=A+B (width rule below) -> GAPW then REQ_S.
//  SEND: op=SEND, write stable until signal=1.
//   On that edge: op<=NOP, req<=0, add_count+1 (only if B!=0).
//   Then B==0 -> HALT, else GAPW then REQ_A.
//  GAPW: GAP cycles with req=0, op=NOP; guarantees the memory sees NOP before the next op.
//  Latency/round: 3 transactions, each = grant wait + memory scan + 1, plus 1 (ADD) + 3*GAP.
//  gnt deasserted while op!=NOP: op forced NOP; state holds and resumes when gnt returns.
//   Arbiter contract: gnt is never revoked after signal fires, before req drops.
//  signal=1 outside FET_x/SEND: ignored, counted as no event.
//  HALT: sticky until reset; req=0, op=NOP, halted=1.
//  Arithmetic: sum is DATA_W+1 internally; default result = low DATA_W bits (wrap).
//   A wrapped sum of 0 is sent as 0; the memory then treats it as empty.
// CONFIGURATION
//  ACC_PROC_SATURATE_EN defined: carry-out forces write = {DATA_W{1'b1}}; sum never wraps to 0.
//  Not defined: modulo 2^DATA_W wrap, no overflow indication.
// TESTING
//  1. Memory {5,7}, gnt tied 1 -> FETCH 5, FETCH 7, SEND 12; next FETCH gets 12, next gets 0
//     -> SEND 12, HALT, add_count=1.
//  2. Memory empty (read=0 on first FETCH) -> HALT after one transaction, no SEND, add_count=0.
//  3. signal pulse on FETCH -> op=NOP by the next edge; memory never sees FETCH while signal=1.
//     Check every cycle.
//  4. gnt held 0 for 20 cycles in REQ_A -> req=1, op=NOP throughout; gnt=1 -> FETCH next cycle.
//  5. A=32'hFFFF_FFFF, B=2 -> write=32'h0000_0001 (no macro); write=32'hFFFF_FFFF with
//     ACC_PROC_SATURATE_EN.
//  6. reset=0 during SEND -> all outputs at reset values same cycle; after release, round
//     restarts with FETCH.

Source files
------------

// File: rtl/accumulator_processor.sv
// accumulator_processor: bus-master adder stage for the shared accumulator memory.
// Each round fetches A and B, adds them, and sends the sum back. The stage halts
// once the memory has nothing left to give.
// Optional build macro ACC_PROC_SATURATE_EN: a sum that carries out is clamped to
// all-ones instead of wrapping.
module accumulator_processor #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int GAP    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gnt,
    input  logic              signal,
    input  logic [DATA_W-1:0] read,
    output logic              req,
    output logic [1:0]        op,
    output logic [DATA_W-1:0] write,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  add_count
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;

    typedef enum logic [3:0] {
        IDLE, REQ_A, FET_A, REQ_B, FET_B, ADD, REQ_S, SEND, GAPW, HALT
    } state_t;

    state_t            state, state_n, ret_st, ret_n;
    logic [1:0]        op_r, op_n;
    logic              req_n, busy_n, halted_n;
    logic [DATA_W-1:0] a_r, a_n, b_r, b_n, write_n, sum_w;
    logic [CNT_W-1:0]  cnt_n;
    logic [GW-1:0]     gap_cnt, gap_n;

`ifdef ACC_PROC_SATURATE_EN
    logic [DATA_W:0] sum_x;
    // Carry-out clamps to all-ones, so a nonzero pair never sums to zero.
    always_comb begin
        sum_x = {1'b0, a_r} + {1'b0, b_r};
        sum_w = sum_x[DATA_W] ? {DATA_W{1'b1}} : sum_x[DATA_W-1:0];
    end
`else
    // Modulo 2^DATA_W: the carry-out is simply dropped.
    always_comb sum_w = a_r + b_r;
`endif

    // The memory only acts on op while we own the bus, so gnt masks it.
    assign op = op_r & {2{gnt}};

    // Next-state and next-register values; every output comes from a flop.
    always_comb begin
        state_n  = state;
        ret_n    = ret_st;
        op_n     = op_r;
        req_n    = req;
        a_n      = a_r;
        b_n      = b_r;
        write_n  = write;
        cnt_n    = add_count;
        gap_n    = gap_cnt;
        case (state)
            IDLE: begin
                state_n = REQ_A;
                req_n   = 1'b1;
            end
            REQ_A, REQ_B, REQ_S: begin
                if (gnt) begin
                    state_n = (state == REQ_A) ? FET_A : (state == REQ_B) ? FET_B : SEND;
                    op_n    = (state == REQ_S) ? OP_SEND : OP_FETCH;
                end
            end
            FET_A: begin
                // A signal while the bus is not ours belongs to another master.
                if (signal && gnt) begin
                    a_n   = read;
                    op_n  = OP_NOP;
                    req_n = 1'b0;
                    if (read == '0) begin
                        state_n = HALT;
                    end else begin
                        state_n = GAPW;
                        ret_n   = REQ_B;
                        gap_n   = GW'(GAP - 1);
                    end
                end
            end
            FET_B: begin
                if (signal && gnt) begin
                    b_n     = read;
                    op_n    = OP_NOP;
                    req_n   = 1'b0;
                    state_n = ADD;
                end
            end
            ADD: begin
                // An empty B means A is the last live value; return it untouched.
                write_n = (b_r == '0) ? a_r : sum_w;
                state_n = GAPW;
                ret_n   = REQ_S;
                gap_n   = GW'(GAP - 1);
            end
            SEND: begin
                if (signal && gnt) begin
                    op_n  = OP_NOP;
                    req_n = 1'b0;
                    if (b_r != '0 && add_count != {CNT_W{1'b1}})
                        cnt_n = add_count + 1'b1;
                    if (b_r == '0) begin
                        state_n = HALT;
                    end else begin
                        state_n = GAPW;
                        ret_n   = REQ_A;
                        gap_n   = GW'(GAP - 1);
                    end
                end
            end
            GAPW: begin
                if (gap_cnt == '0) begin
                    state_n = ret_st;
                    req_n   = 1'b1;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            HALT:    state_n = HALT;
            default: state_n = IDLE;
        endcase
        busy_n   = !(state_n == IDLE || state_n == HALT);
        halted_n = (state_n == HALT);
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ret_st    <= REQ_A;
            op_r      <= OP_NOP;
            req       <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            write     <= '0;
            add_count <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state     <= state_n;
            ret_st    <= ret_n;
            op_r      <= op_n;
            req       <= req_n;
            a_r       <= a_n;
            b_r       <= b_n;
            write     <= write_n;
            add_count <= cnt_n;
            gap_cnt   <= gap_n;
            busy      <= busy_n;
            halted    <= halted_n;
        end
    end

endmodule

// File: tb/tb_accumulator_processor.sv
// Bench for accumulator_processor: a FIFO memory model answers FETCH/SEND, an
// abstract round-by-round model predicts the transaction log, and a per-cycle
// process checks bus rules, add_count and halt timing.
module tb_accumulator_processor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        gnt = 1'b0;
    logic        signal;
    logic [31:0] read;
    logic        req, busy, halted;
    logic [1:0]  op;
    logic [31:0] write;
    logic [15:0] add_count;

    int total = 0;
    int bad   = 0;

    accumulator_processor #(.DATA_W(32), .CNT_W(16), .GAP(1)) dut (
        .clk(clk), .reset(reset), .gnt(gnt), .signal(signal), .read(read),
        .req(req), .op(op), .write(write), .busy(busy), .halted(halted),
        .add_count(add_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memory model: FIFO population, fixed latency, one-cycle completion pulse.
    logic [31:0] mem_init[$];
    logic [31:0] mem_q[$];
    int          lat = 2;
    logic        mbusy = 1'b0;
    logic [1:0]  mkind;
    logic [31:0] mwr;
    int          mcnt;
    int          act_kind[$];
    logic [31:0] act_val[$];
    int          done_n = 0;

    always @(posedge clk) begin
        logic [31:0] v;
        if (!reset) begin
            signal <= 1'b0;
            read   <= '0;
            mbusy  = 1'b0;
        end else if (signal) begin
            signal <= 1'b0;
            done_n = done_n + 1;
        end else if (mbusy) begin
            if (mcnt == 0) begin
                mbusy  = 1'b0;
                signal <= 1'b1;
                if (mkind == 2'b01) begin
                    v = (mem_q.size() > 0) ? mem_q.pop_front() : 32'd0;
                    read <= v;
                    act_kind.push_back(1);
                    act_val.push_back(v);
                end else begin
                    if (mwr != 0) mem_q.push_back(mwr);
                    act_kind.push_back(2);
                    act_val.push_back(mwr);
                end
            end else begin
                mcnt = mcnt - 1;
            end
        end else if (op != 2'b00) begin
            mbusy = 1'b1;
            mkind = op;
            mwr   = write;
            mcnt  = lat;
        end
    end

    // Abstract model: plays rounds on a copy of the population.
    int          exp_kind[$];
    logic [31:0] exp_val[$];
    int          exp_pref[$];

    task automatic add_exp(input int k, input logic [31:0] v, input int inc);
        exp_kind.push_back(k);
        exp_val.push_back(v);
        exp_pref.push_back(exp_pref[exp_pref.size()-1] + inc);
    endtask

    task automatic build_exp();
        logic [31:0] q[$];
        logic [31:0] a, b, w;
        logic [32:0] s;
        q = mem_init;
        exp_kind.delete();
        exp_val.delete();
        exp_pref.delete();
        exp_pref.push_back(0);
        for (int g = 0; g < 1000; g++) begin
            a = (q.size() > 0) ? q.pop_front() : 32'd0;
            add_exp(1, a, 0);
            if (a == 0) break;
            b = (q.size() > 0) ? q.pop_front() : 32'd0;
            add_exp(1, b, 0);
            if (b == 0) begin
                add_exp(2, a, 0);
                break;
            end
            s = {1'b0, a} + {1'b0, b};
`ifdef ACC_PROC_SATURATE_EN
            w = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
            w = s[31:0];
`endif
            add_exp(2, w, 1);
            if (w != 0) q.push_back(w);
        end
    endtask

    // Per-cycle checks plus the random arbiter (mode 2 holds gnt until req drops).
    logic chk_en = 1'b0;
    logic prev_sig = 1'b0;
    int   gmode = 1;

    always @(negedge clk) begin
        if (reset && chk_en) begin
            if (!gnt) chk("op_nogrant", op, 0);
            if (prev_sig) chk("op_after_signal", op, 0);
            if (done_n < exp_pref.size()) chk("add_count_cycle", add_count, exp_pref[done_n]);
            chk("halted_timing", halted, done_n == exp_kind.size());
            if (halted) chk("halt_quiet", {req, op, busy}, 0);
        end
        prev_sig = signal;
        if (gmode == 2) begin
            if (!req) gnt = 1'($urandom_range(0, 1));
            else if (!gnt) gnt = 1'($urandom_range(0, 1));
        end
    end

    task automatic start_case(input int m, input int l);
        chk_en = 1'b0;
        reset  = 1'b0;
        gmode  = m;
        gnt    = (m == 1);
        lat    = l;
        repeat (2) @(posedge clk);
        #2;
        mem_q = mem_init;
        act_kind.delete();
        act_val.delete();
        done_n   = 0;
        prev_sig = 1'b0;
        build_exp();
        reset  = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic finish_case(input string nm);
        int n = 0;
        while (!halted && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_halt"}, halted, 1);
        chk({nm, "_len"}, act_kind.size(), exp_kind.size());
        for (int i = 0; i < act_kind.size() && i < exp_kind.size(); i++) begin
            chk({nm, "_kind"}, act_kind[i], exp_kind[i]);
            chk({nm, "_val"}, act_val[i], exp_val[i]);
        end
        chk({nm, "_count"}, add_count, exp_pref[exp_pref.size()-1]);
        chk({nm, "_busy"}, busy, 0);
    endtask

    initial begin
        int n;
        #1;
        chk("reset_outs", {req, op, write, busy, halted, add_count}, 0);

        // {5,7}: F5 F7 S12 F12 F0 S12, one counted addition.
        mem_init = {32'd5, 32'd7};
        start_case(1, 2);
        finish_case("t1");
        chk("t1_pin_len", act_kind.size(), 6);
        chk("t1_pin_s1", {act_kind[2], act_val[2]}, {32'd2, 32'd12});
        chk("t1_pin_s2", {act_kind[5], act_val[5]}, {32'd2, 32'd12});
        chk("t1_pin_cnt", add_count, 1);

        // Empty memory: one FETCH of 0, then HALT.
        mem_init.delete();
        start_case(1, 1);
        finish_case("t2");
        chk("t2_pin_len", act_kind.size(), 1);
        chk("t2_pin_cnt", add_count, 0);

        // Longer population under a random arbiter.
        mem_init = {32'd3, 32'd4, 32'd10, 32'd1, 32'd8};
        start_case(2, 3);
        finish_case("t3");
        chk("t3_pin_cnt", add_count, 4);
        chk("t3_pin_last", act_val[act_val.size()-1], 32'd26);

        // Grant withheld for 20 cycles in REQ_A.
        mem_init = {32'd9, 32'd6};
        start_case(0, 2);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("t4_req_wait", {req, op}, 3'b100);
        end
        gnt   = 1'b1;
        gmode = 1;
        @(posedge clk);
        #1;
        chk("t4_fetch_next", op, 2'b01);
        finish_case("t4");

        // Overflow on the first sum.
        mem_init = {32'hFFFF_FFFF, 32'd2};
        start_case(1, 1);
        finish_case("t5");
`ifdef ACC_PROC_SATURATE_EN
        chk("t5_pin_sum", act_val[2], 32'hFFFF_FFFF);
`else
        chk("t5_pin_sum", act_val[2], 32'h0000_0001);
`endif

        // Sum that wraps to exactly zero (or clamps when saturating).
        mem_init = {32'hFFFF_FFFF, 32'd1};
        start_case(1, 0);
        finish_case("t7");

        // Reset asserted mid-SEND, then a clean restart.
        mem_init = {32'd5, 32'd7};
        start_case(1, 2);
        n = 0;
        while (op != 2'b10 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_in_send", op, 2'b10);
        chk_en = 1'b0;
        reset  = 1'b0;
        #1;
        chk("t6_reset_outs", {req, op, write, busy, halted, add_count}, 0);
        start_case(1, 2);
        n = 0;
        while (op == 2'b00 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_restart_fetch", op, 2'b01);
        finish_case("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
